// File: rtl/program_counter_pkg.sv
// Shared fetch-path constants and the redirect-select encoding for the program counter.
package program_counter_pkg;

   localparam int ADDR_WIDTH  = 13;
   localparam int STACK_DEPTH = 8;
   localparam int SP_WIDTH    = $clog2(STACK_DEPTH);

   localparam logic [ADDR_WIDTH-1:0] RESET_VECTOR = 13'h0000;
   localparam logic [ADDR_WIDTH-1:0] ISR_VECTOR   = 13'h0004;

   typedef enum logic [2:0] {
      PC_HOLD,
      PC_INT,
      PC_RET,
      PC_CALL,
      PC_GOTO,
      PC_PCL,
      PC_INC
   } pc_sel_e;

   // One op per cycle: the highest-priority request wins, the rest are dropped.
   function automatic pc_sel_e pc_select(input logic stall, input logic op_int,
                                         input logic op_return, input logic op_call,
                                         input logic op_goto, input logic pcl_we);
      if (stall)          return PC_HOLD;
      else if (op_int)    return PC_INT;
      else if (op_return) return PC_RET;
      else if (op_call)   return PC_CALL;
      else if (op_goto)   return PC_GOTO;
      else if (pcl_we)    return PC_PCL;
      else                return PC_INC;
   endfunction

endpackage

// File: rtl/program_counter_if.sv
// Redirect requests from the decoder in, fetch address and status to program memory / file regs out.
interface program_counter_if;
   import program_counter_pkg::*;

   logic                  stall;
   logic                  op_goto;
   logic                  op_call;
   logic                  op_return;
   logic                  op_int;
   logic                  pcl_we;
   logic [10:0]           k;
   logic [4:0]            pclath;
   logic [7:0]            pcl_wdata;
   logic [ADDR_WIDTH-1:0] pc;
   logic                  rd_en;
   logic                  flush;
   logic [7:0]            pcl;
   logic                  stk_overflow;
   logic                  stk_underflow;

   modport master (
      output stall, op_goto, op_call, op_return, op_int, pcl_we, k, pclath, pcl_wdata,
      input  pc, rd_en, flush, pcl, stk_overflow, stk_underflow
   );

   modport slave (
      input  stall, op_goto, op_call, op_return, op_int, pcl_we, k, pclath, pcl_wdata,
      output pc, rd_en, flush, pcl, stk_overflow, stk_underflow
   );

endinterface

// File: rtl/program_counter_return_stack.sv
// Circular hardware return stack: push writes at sp, pop reads sp-1; dout is combinational.
module return_stack
   import program_counter_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_push,
   input  logic                  i_pop,
   input  logic [ADDR_WIDTH-1:0] i_din,
   output logic [ADDR_WIDTH-1:0] o_dout,
   output logic                  o_overflow,
   output logic                  o_underflow
);

   logic [ADDR_WIDTH-1:0] r_mem [STACK_DEPTH];
   logic [SP_WIDTH-1:0]   r_sp;
   logic [SP_WIDTH:0]     r_count;
   logic [SP_WIDTH-1:0]   w_sp_dec;
   logic                  w_full;
   logic                  w_empty;

   assign w_sp_dec = r_sp - SP_WIDTH'(1);
   assign w_full   = (r_count == (SP_WIDTH+1)'(STACK_DEPTH));
   assign w_empty  = (r_count == '0);
   assign o_dout   = r_mem[w_sp_dec];

   // Entries are deliberately left unreset; only the pointer state is cleared.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_sp] <= i_din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sp        <= '0;
         r_count     <= '0;
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else if (i_push) begin
         r_sp <= r_sp + SP_WIDTH'(1);
         if (w_full) begin
            o_overflow <= 1'b1;
         end else begin
            r_count <= r_count + (SP_WIDTH+1)'(1);
         end
      end else if (i_pop) begin
         r_sp <= w_sp_dec;
         if (w_empty) begin
            o_underflow <= 1'b1;
         end else begin
            r_count <= r_count - (SP_WIDTH+1)'(1);
         end
      end
   end

endmodule

// File: rtl/program_counter.sv
// Fetch-address generator: priority redirect mux, PC register, return stack, flush/rd_en to program memory.
module program_counter
   import program_counter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   program_counter_if.slave  bus
);

   logic [ADDR_WIDTH-1:0] r_pc;
   logic [ADDR_WIDTH-1:0] w_next_pc;
   logic [ADDR_WIDTH-1:0] w_stk_dout;
   pc_sel_e               w_sel;
   logic                  w_push;
   logic                  w_pop;

   always_comb begin
      w_sel     = pc_select(bus.stall, bus.op_int, bus.op_return,
                            bus.op_call, bus.op_goto, bus.pcl_we);
      w_next_pc = r_pc + ADDR_WIDTH'(1);
      w_push    = 1'b0;
      w_pop     = 1'b0;
      case (w_sel)
         PC_HOLD: w_next_pc = r_pc;
         PC_INT: begin
            w_next_pc = ISR_VECTOR;
            w_push    = 1'b1;
         end
         PC_RET: begin
            w_next_pc = w_stk_dout;
            w_pop     = 1'b1;
         end
         PC_CALL: begin
            w_next_pc = {bus.pclath[4:3], bus.k};
            w_push    = 1'b1;
         end
         PC_GOTO: w_next_pc = {bus.pclath[4:3], bus.k};
         PC_PCL:  w_next_pc = {bus.pclath, bus.pcl_wdata};
         default: w_next_pc = r_pc + ADDR_WIDTH'(1);
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc <= RESET_VECTOR;
      end else begin
         r_pc <= w_next_pc;
      end
   end

   // The pushed return address is the current fetch address, since the executing op sits at pc-1.
   return_stack u_stack (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_pop       (w_pop),
      .i_din       (r_pc),
      .o_dout      (w_stk_dout),
      .o_overflow  (bus.stk_overflow),
      .o_underflow (bus.stk_underflow)
   );

   assign bus.pc    = r_pc;
   assign bus.pcl   = r_pc[7:0];
   assign bus.rd_en = ~rst & ~bus.stall;
   assign bus.flush = ~rst & (w_sel != PC_HOLD) & (w_sel != PC_INC);

endmodule

// File: tb/tb_program_counter.sv
// Directed checks of program_counter: sequencing, redirects, stack wrap/flags, priority, stall, async reset.
module tb_program_counter;

   logic clk = 1'b0;
   logic rst;
   int   n_pass  = 0;
   int   n_total = 0;

   program_counter_if bus ();

   program_counter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic clr_ops();
      bus.stall     = 1'b0;
      bus.op_goto   = 1'b0;
      bus.op_call   = 1'b0;
      bus.op_return = 1'b0;
      bus.op_int    = 1'b0;
      bus.pcl_we    = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_pcl(input logic [4:0] hi, input logic [7:0] lo);
      bus.pclath    = hi;
      bus.pcl_wdata = lo;
      bus.pcl_we    = 1'b1;
      step();
      clr_ops();
   endtask

   initial begin
      clr_ops();
      bus.k         = '0;
      bus.pclath    = '0;
      bus.pcl_wdata = '0;
      rst           = 1'b1;

      // Reset state, including flush held low despite a pending op.
      bus.op_goto = 1'b1;
      #2;
      chk("rst_pc", bus.pc, 32'h0);
      chk("rst_rd_en", bus.rd_en, 32'h0);
      chk("rst_flush", bus.flush, 32'h0);
      step();
      step();
      chk("rst_pc_held", bus.pc, 32'h0);
      clr_ops();
      rst = 1'b0;
      #1;
      chk("rel_rd_en", bus.rd_en, 32'h1);
      chk("rel_flush", bus.flush, 32'h0);
      chk("rel_ovf", bus.stk_overflow, 32'h0);
      chk("rel_unf", bus.stk_underflow, 32'h0);

      for (int i = 1; i <= 3; i++) begin
         step();
         chk($sformatf("inc_pc%0d", i), bus.pc, 32'(i));
         chk($sformatf("inc_flush%0d", i), bus.flush, 32'h0);
      end

      // GOTO with PCLATH page bits.
      bus.pclath  = 5'h18;
      bus.k       = 11'h123;
      bus.op_goto = 1'b1;
      #1;
      chk("goto_flush", bus.flush, 32'h1);
      step();
      clr_ops();
      chk("goto_pc", bus.pc, 32'h1923);

      // Computed jump, then CALL / RETURN.
      load_pcl(5'h00, 8'h50);
      chk("pcl_pc", bus.pc, 32'h0050);
      chk("pcl_out", bus.pcl, 32'h50);
      bus.k       = 11'h200;
      bus.op_call = 1'b1;
      step();
      clr_ops();
      chk("call_pc", bus.pc, 32'h0200);
      step();
      step();
      step();
      chk("call_inc_pc", bus.pc, 32'h0203);
      bus.op_return = 1'b1;
      step();
      clr_ops();
      chk("ret_pc", bus.pc, 32'h0050);
      chk("ret_ovf", bus.stk_overflow, 32'h0);
      chk("ret_unf", bus.stk_underflow, 32'h0);

      // Nine nested calls: pushed 0x077, 0x110, ..., 0x180; the 9th overwrites the oldest.
      load_pcl(5'h00, 8'h77);
      for (int i = 1; i <= 9; i++) begin
         bus.k       = 11'(12'h100 + i * 16);
         bus.op_call = 1'b1;
         step();
         clr_ops();
         chk($sformatf("nest_pc%0d", i), bus.pc, 32'(12'h100 + i * 16));
         chk($sformatf("nest_ovf%0d", i), bus.stk_overflow, (i == 9) ? 32'h1 : 32'h0);
      end
      for (int j = 1; j <= 9; j++) begin
         bus.op_return = 1'b1;
         step();
         clr_ops();
         chk($sformatf("unw_pc%0d", j), bus.pc,
             (j <= 8) ? 32'(12'h100 + (9 - j) * 16) : 32'h0180);
         chk($sformatf("unw_unf%0d", j), bus.stk_underflow, (j == 9) ? 32'h1 : 32'h0);
      end

      // Interrupt beats a simultaneous call; exactly one push.
      rst = 1'b1;
      #1;
      chk("rst2_unf", bus.stk_underflow, 32'h0);
      chk("rst2_ovf", bus.stk_overflow, 32'h0);
      step();
      rst = 1'b0;
      load_pcl(5'h01, 8'h00);
      chk("int_pre_pc", bus.pc, 32'h0100);
      bus.k       = 11'h555;
      bus.op_int  = 1'b1;
      bus.op_call = 1'b1;
      #1;
      chk("int_flush", bus.flush, 32'h1);
      step();
      clr_ops();
      chk("int_pc", bus.pc, 32'h0004);
      bus.op_return = 1'b1;
      step();
      clr_ops();
      chk("int_ret_pc", bus.pc, 32'h0100);
      chk("int_ret_unf", bus.stk_underflow, 32'h0);
      bus.op_return = 1'b1;
      step();
      clr_ops();
      chk("int_ret2_unf", bus.stk_underflow, 32'h1);

      // Stall holds everything while a GOTO is pending.
      load_pcl(5'h00, 8'hAA);
      bus.pclath  = 5'h00;
      bus.k       = 11'h3FF;
      bus.stall   = 1'b1;
      bus.op_goto = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("stall_rd_en%0d", i), bus.rd_en, 32'h0);
         chk($sformatf("stall_flush%0d", i), bus.flush, 32'h0);
         step();
         chk($sformatf("stall_pc%0d", i), bus.pc, 32'h00AA);
      end
      bus.stall = 1'b0;
      #1;
      chk("unstall_flush", bus.flush, 32'h1);
      chk("unstall_rd_en", bus.rd_en, 32'h1);
      step();
      clr_ops();
      chk("unstall_pc", bus.pc, 32'h03FF);

      // Top-of-memory wrap.
      load_pcl(5'h1F, 8'hFF);
      chk("wrap_pre_pc", bus.pc, 32'h1FFF);
      step();
      chk("wrap_pc", bus.pc, 32'h0000);

      // Async reset mid-call clears PC and flags before any edge.
      chk("pre_rst_unf", bus.stk_underflow, 32'h1);
      bus.k       = 11'h007;
      bus.op_call = 1'b1;
      #1;
      chk("midcall_flush", bus.flush, 32'h1);
      #1;
      rst = 1'b1;
      #1;
      chk("arst_pc", bus.pc, 32'h0);
      chk("arst_unf", bus.stk_underflow, 32'h0);
      chk("arst_flush", bus.flush, 32'h0);
      chk("arst_rd_en", bus.rd_en, 32'h0);
      clr_ops();
      step();
      rst = 1'b0;
      step();
      chk("post_rst_pc", bus.pc, 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
